hamming_enc_seq: RTL and testbench

Sequencer that drives the shared 8-bit ALU through its parity and packing ops to turn an 11-bit data word into a 16-bit Hamming-encoded word (LSW/MSW pair). It sits beside the ALU in the core. It owns the ALU `op` and operand buses while busy, and accumulates results in internal registers. When the encoded pair is complete, it presents it with a one-cycle `done` pulse.

---
 rtl/hamming_enc_seq.sv | 213 +++++++++++++++++++++
 tb/tb_hamming_enc_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_enc_seq.sv
// Sequencer that drives a shared 8-bit ALU to build a 16-bit Hamming word from 11 data bits.
// Optional ALU arbitration (alu_req/alu_gnt) is enabled by defining HAMMING_ENC_SEQ_ARB_EN.
module hamming_enc_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [10:0] data_in,
    output logic [3:0]  alu_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    input  logic [7:0]  alu_result,
    output logic        busy,
    output logic        done,
    output logic [7:0]  enc_lsw,
    output logic [7:0]  enc_msw
`ifdef HAMMING_ENC_SEQ_ARB_EN
    ,
    output logic        alu_req,
    input  logic        alu_gnt
`endif
);

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_P0  = 4'b1000;
    localparam logic [3:0] OP_P1  = 4'b1001;
    localparam logic [3:0] OP_P2  = 4'b1010;
    localparam logic [3:0] OP_P4  = 4'b1011;
    localparam logic [3:0] OP_P8  = 4'b1100;
    localparam logic [3:0] OP_PKL = 4'b1101;
    localparam logic [3:0] OP_PKM = 4'b1110;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_PKL  = 4'd1,
        S_PKM  = 4'd2,
        S_P1   = 4'd3,
        S_P2   = 4'd4,
        S_P4   = 4'd5,
        S_P8   = 4'd6,
        S_P0   = 4'd7,
        S_DONE = 4'd8
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [10:0] dreg_r;
    logic [10:0] dreg_nxt_s;
    logic [7:0]  lsw_acc_r;
    logic [7:0]  lsw_nxt_s;
    logic [7:0]  msw_acc_r;
    logic [7:0]  msw_nxt_s;
    logic        gnt_s;
    logic        compute_s;
    logic        adv_s;
    logic [3:0]  op_nxt_s;
    logic [7:0]  a_nxt_s;
    logic [7:0]  b_nxt_s;
    logic        busy_nxt_s;
    logic        done_nxt_s;
    logic        req_nxt_s;
    logic        req_r;

`ifdef HAMMING_ENC_SEQ_ARB_EN
    assign gnt_s   = alu_gnt;
    assign alu_req = req_r;
`else
    assign gnt_s   = 1'b1;
`endif

    // ALU command belonging to each state; IDLE and DONE leave the ALU idle.
    function automatic logic [3:0] op_of(input state_t s);
        logic [3:0] op;
        case (s)
            S_PKL:   op = OP_PKL;
            S_PKM:   op = OP_PKM;
            S_P1:    op = OP_P1;
            S_P2:    op = OP_P2;
            S_P4:    op = OP_P4;
            S_P8:    op = OP_P8;
            S_P0:    op = OP_P0;
            default: op = OP_NOP;
        endcase
        return op;
    endfunction

    function automatic logic is_compute(input state_t s);
        return (s != S_IDLE) && (s != S_DONE);
    endfunction

    assign compute_s = is_compute(state_r);
    assign adv_s     = compute_s && gnt_s;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: compute states advance only when the ALU is granted.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE:  state_nxt_s = start ? S_PKL : S_IDLE;
            S_PKL:   state_nxt_s = adv_s ? S_PKM : S_PKL;
            S_PKM:   state_nxt_s = adv_s ? S_P1  : S_PKM;
            S_P1:    state_nxt_s = adv_s ? S_P2  : S_P1;
            S_P2:    state_nxt_s = adv_s ? S_P4  : S_P2;
            S_P4:    state_nxt_s = adv_s ? S_P8  : S_P4;
            S_P8:    state_nxt_s = adv_s ? S_P0  : S_P8;
            S_P0:    state_nxt_s = adv_s ? S_DONE : S_P0;
            S_DONE:  state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Accumulator update: capture or merge the ALU result of the current compute state.
    always_comb begin
        dreg_nxt_s = dreg_r;
        lsw_nxt_s  = lsw_acc_r;
        msw_nxt_s  = msw_acc_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    dreg_nxt_s = data_in;
                    lsw_nxt_s  = 8'h00;
                    msw_nxt_s  = 8'h00;
                end else begin
                    dreg_nxt_s = dreg_r;
                end
            end
            S_PKL: begin
                if (adv_s) lsw_nxt_s = alu_result;
                else       lsw_nxt_s = lsw_acc_r;
            end
            S_PKM: begin
                if (adv_s) msw_nxt_s = alu_result;
                else       msw_nxt_s = msw_acc_r;
            end
            S_P1, S_P2, S_P4: begin
                if (adv_s) lsw_nxt_s = lsw_acc_r | alu_result;
                else       lsw_nxt_s = lsw_acc_r;
            end
            S_P8: begin
                if (adv_s) msw_nxt_s = msw_acc_r | {7'b0000000, alu_result[0]};
                else       msw_nxt_s = msw_acc_r;
            end
            S_P0: begin
                if (adv_s) lsw_nxt_s = lsw_acc_r | {7'b0000000, alu_result[0]};
                else       lsw_nxt_s = lsw_acc_r;
            end
            default: begin
                dreg_nxt_s = dreg_r;
            end
        endcase
    end

    // Output decode from the upcoming state so that the registered ALU bus lines up with it.
    always_comb begin
        op_nxt_s   = op_of(state_nxt_s);
        a_nxt_s    = 8'h00;
        b_nxt_s    = 8'h00;
        busy_nxt_s = (state_nxt_s != S_IDLE);
        done_nxt_s = (state_nxt_s == S_DONE);
        req_nxt_s  = is_compute(state_nxt_s);
        if (state_nxt_s == S_P0) begin
            a_nxt_s = lsw_nxt_s;
            b_nxt_s = msw_nxt_s;
        end else if (is_compute(state_nxt_s)) begin
            a_nxt_s = dreg_nxt_s[7:0];
            b_nxt_s = {5'b00000, dreg_nxt_s[10:8]};
        end else begin
            a_nxt_s = 8'h00;
            b_nxt_s = 8'h00;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dreg_r    <= 11'h000;
            lsw_acc_r <= 8'h00;
            msw_acc_r <= 8'h00;
            alu_op    <= 4'b0000;
            alu_a     <= 8'h00;
            alu_b     <= 8'h00;
            busy      <= 1'b0;
            done      <= 1'b0;
            req_r     <= 1'b0;
        end else begin
            dreg_r    <= dreg_nxt_s;
            lsw_acc_r <= lsw_nxt_s;
            msw_acc_r <= msw_nxt_s;
            alu_op    <= op_nxt_s;
            alu_a     <= a_nxt_s;
            alu_b     <= b_nxt_s;
            busy      <= busy_nxt_s;
            done      <= done_nxt_s;
            req_r     <= req_nxt_s;
        end
    end

`ifndef HAMMING_ENC_SEQ_ARB_EN
    logic unused_req_s;
    assign unused_req_s = req_r;
`endif

    assign enc_lsw = lsw_acc_r;
    assign enc_msw = msw_acc_r;

endmodule

// File: tb/tb_hamming_enc_seq.sv
// Randomized bench for hamming_enc_seq with a behavioural ALU and a position-based Hamming model.
module tb_hamming_enc_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [10:0] data_in;
    logic [3:0]  alu_op;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [7:0]  alu_result;
    logic        busy;
    logic        done;
    logic [7:0]  enc_lsw;
    logic [7:0]  enc_msw;
`ifdef HAMMING_ENC_SEQ_ARB_EN
    logic        alu_req;
    logic        alu_gnt;
`endif

    int errors = 0;
    int checks = 0;

    hamming_enc_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .data_in    (data_in),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .busy       (busy),
        .done       (done),
        .enc_lsw    (enc_lsw),
        .enc_msw    (enc_msw)
`ifdef HAMMING_ENC_SEQ_ARB_EN
        ,
        .alu_req    (alu_req),
        .alu_gnt    (alu_gnt)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural shared ALU: packing and parity ops with the data word {B[2:0], A}.
    function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [10:0] d;
        d = {b[2:0], a};
        case (op)
            4'b1101: return {a[3], a[2], a[1], 1'b0, a[0], 3'b000};
            4'b1110: return {b[2:0], a[7:4], 1'b0};
            4'b1001: return {6'b000000, ^(d & 11'h55B), 1'b0};
            4'b1010: return {5'b00000, ^(d & 11'h66D), 2'b00};
            4'b1011: return {3'b000, ^(d & 11'h78E), 4'b0000};
            4'b1100: return {7'b0000000, ^(d & 11'h7F0)};
            4'b1000: return {7'b0000000, ^{a, b}};
            default: return 8'h00;
        endcase
    endfunction

    always_comb alu_result = alu_fn(alu_op, alu_a, alu_b);

    // Reference: bit i of the 16-bit word is Hamming position i; p0 is overall parity.
    function automatic logic [15:0] ref_enc(input logic [10:0] d);
        logic [15:0] w;
        logic        par;
        int          k;
        w = 16'h0000;
        k = 0;
        for (int pos = 1; pos < 16; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                w[pos] = d[k];
                k++;
            end
        end
        for (int p = 1; p < 16; p = p * 2) begin
            par = 1'b0;
            for (int pos = 1; pos < 16; pos++)
                if (((pos & p) != 0) && (pos != p)) par = par ^ w[pos];
            w[p] = par;
        end
        w[0] = ^w;
        return w;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One encode transaction, watched for 20 cycles after the start edge.
    task automatic encode(input logic [10:0] d, input bit extra_starts, input bit check_ops,
                          input int stall_at, input int stall_len);
        logic [15:0] w;
        logic [3:0]  ops [0:20];
        logic [3:0]  exp_ops [0:7];
        int          done_cyc;
        int          done_cnt;
        exp_ops = '{4'hD, 4'hE, 4'h9, 4'hA, 4'hB, 4'hC, 4'h8, 4'h0};
        w = ref_enc(d);
        done_cyc = -1;
        done_cnt = 0;
        @(negedge clk);
        start   = 1'b1;
        data_in = d;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            ops[cyc] = alu_op;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (cyc == 1) check_val("busy_after_start", {31'd0, busy}, 32'd1);
            if (stall_len > 0 && cyc >= stall_at && cyc <= stall_at + stall_len)
                check_val("op_held_in_stall", {28'd0, alu_op}, {28'd0, exp_ops[stall_at - 1]});
            start   = extra_starts && (cyc == 3 || cyc == 8);
            data_in = 11'($urandom);
`ifdef HAMMING_ENC_SEQ_ARB_EN
            alu_gnt = !(stall_len > 0 && cyc >= stall_at && cyc < stall_at + stall_len);
`endif
        end
        start = 1'b0;
`ifdef HAMMING_ENC_SEQ_ARB_EN
        alu_gnt = 1'b1;
`endif
        check_val("done_count", done_cnt, 32'd1);
        check_val("done_latency", done_cyc, 8 + stall_len);
        check_val("enc_lsw", {24'd0, enc_lsw}, {24'd0, w[7:0]});
        check_val("enc_msw", {24'd0, enc_msw}, {24'd0, w[15:8]});
        check_val("busy_idle", {31'd0, busy}, 32'd0);
        if (check_ops)
            for (int i = 0; i < 8; i++)
                check_val($sformatf("op_seq_%0d", i + 1), {28'd0, ops[i + 1]}, {28'd0, exp_ops[i]});
    endtask

    task automatic check_all_zero(input string tag);
        check_val(tag, {alu_op, alu_a, alu_b, busy, done, enc_lsw, enc_msw}, 32'd0);
    endtask

    initial begin
        logic [10:0] d;
        logic [15:0] w;
        int          dn [$];
        int          sl;
        rst_n   = 1'b0;
        start   = 1'b0;
        data_in = 11'h000;
`ifdef HAMMING_ENC_SEQ_ARB_EN
        alu_gnt = 1'b1;
`endif
        repeat (2) @(negedge clk);
        check_all_zero("reset_state");
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("idle_after_reset");

        encode(11'h7FF, 1'b0, 1'b1, 0, 0);
        encode(11'h001, 1'b0, 1'b0, 0, 0);
        encode(11'h400, 1'b0, 1'b0, 0, 0);
        encode(11'h000, 1'b0, 1'b1, 0, 0);
        encode(11'h2A5, 1'b1, 1'b0, 0, 0);

        // Reset during P2 aborts the sequence with no done pulse.
        @(negedge clk);
        start   = 1'b1;
        data_in = 11'h5A3;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check_val("in_p2_before_reset", {28'd0, alu_op}, 32'hA);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset_midseq");
        @(negedge clk);
        rst_n = 1'b1;
        sl = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            if (done || busy) sl++;
        end
        check_val("no_done_after_abort", sl, 32'd0);
        encode(11'h7FF, 1'b0, 1'b0, 0, 0);

`ifdef HAMMING_ENC_SEQ_ARB_EN
        encode(11'h7FF, 1'b0, 1'b0, 5, 3);
`endif

        for (int n = 0; n < 24; n++) begin
            sl = 0;
`ifdef HAMMING_ENC_SEQ_ARB_EN
            sl = $urandom_range(3, 0);
`endif
            encode(11'($urandom), 1'($urandom_range(1, 0)), 1'b0, $urandom_range(7, 1), sl);
        end

        // Held start re-triggers every 9 cycles.
        d = 11'h3C6;
        w = ref_enc(d);
        @(negedge clk);
        start   = 1'b1;
        data_in = d;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (done) begin
                dn.push_back(cyc);
                check_val("held_start_word", {enc_msw, enc_lsw}, {16'd0, w});
            end
        end
        start = 1'b0;
        check_val("held_start_dones", dn.size(), 32'd2);
        if (dn.size() == 2) begin
            check_val("held_start_first", dn[0], 32'd8);
            check_val("held_start_spacing", dn[1] - dn[0], 32'd9);
        end
        sl = 0;
        while (busy && sl < 30) begin
            @(negedge clk);
            sl++;
        end
        check_val("held_start_settles", {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
